demux_1_to_8_buffered: RTL and testbench

//   Write-direction counterpart of the 8:1 select path: routes one WIDTH-bit input

---
 rtl/demux_1_to_8_buffered.sv | 94 +++++++++
 tb/tb_demux_1_to_8_buffered.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/demux_1_to_8_buffered.sv
// rtl/demux_1_to_8_buffered.sv - 1:8 router with one-deep valid/ready holding register per lane
module demux_1_to_8_buffered #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [7:0]       out_valid,
    input  logic [7:0]       out_ready,
    output logic [3:0]       pending
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lane_state_t;

    lane_state_t      state_q [8];
    lane_state_t      state_d [8];
    logic [WIDTH-1:0] data_q  [8];
    logic [3:0]       pending_d;
    logic             accept;

    // Only the addressed lane can stall the producer.
    assign in_ready = !rst && (!out_valid[sel] || out_ready[sel]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid = '0;
        for (int n = 0; n < 8; n++) begin
            out_valid[n] = (state_q[n] == FULL);
        end
    end

    always_comb begin
        pending_d = '0;
        for (int n = 0; n < 8; n++) begin
            state_d[n] = state_q[n];
            case (state_q[n])
                EMPTY: begin
                    if (accept && sel == 3'(n)) begin
                        state_d[n] = FULL;
                    end
                end
                FULL: begin
                    if (out_ready[n] && !(accept && sel == 3'(n))) begin
                        state_d[n] = EMPTY;
                    end
                end
                default: state_d[n] = EMPTY;
            endcase
            pending_d = pending_d + 4'(state_d[n] == FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                state_q[n] <= EMPTY;
                data_q[n]  <= '0;
            end
            pending <= '0;
        end else begin
            for (int n = 0; n < 8; n++) begin
                state_q[n] <= state_d[n];
                if (accept && sel == 3'(n)) begin
                    data_q[n] <= in_data;
                end
            end
            pending <= pending_d;
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];
    assign out4 = data_q[4];
    assign out5 = data_q[5];
    assign out6 = data_q[6];
    assign out7 = data_q[7];

endmodule

// File: tb/tb_demux_1_to_8_buffered.sv
// tb/tb_demux_1_to_8_buffered.sv - randomized and directed check of demux_1_to_8_buffered against a lane model
module tb_demux_1_to_8_buffered;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       sel = '0;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5, out6, out7;
    logic [7:0]       out_valid;
    logic [7:0]       out_ready = '0;
    logic [3:0]       pending;

    logic [WIDTH-1:0] dut_out [8];
    logic [7:0]       m_valid;
    logic [WIDTH-1:0] m_data [8];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    demux_1_to_8_buffered #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .in_data(in_data),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7),
        .out_valid(out_valid), .out_ready(out_ready), .pending(pending)
    );

    assign dut_out[0] = out0;
    assign dut_out[1] = out1;
    assign dut_out[2] = out2;
    assign dut_out[3] = out3;
    assign dut_out[4] = out4;
    assign dut_out[5] = out5;
    assign dut_out[6] = out6;
    assign dut_out[7] = out7;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, check in_ready before the edge, then the registered state after it.
    task automatic drive(input bit r, input bit iv, input int s, input logic [31:0] d, input logic [7:0] ordy);
        bit exp_rdy;
        rst = r;
        in_valid = iv;
        sel = 3'(s);
        in_data = d;
        out_ready = ordy;
        #1;
        exp_rdy = !r && (!m_valid[sel] || ordy[sel]);
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_valid = '0;
            for (int n = 0; n < 8; n++) m_data[n] = '0;
        end else begin
            m_valid = m_valid & ~ordy;
            if (iv && exp_rdy) begin
                m_valid[sel] = 1'b1;
                m_data[sel] = d;
            end
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("pending", 32'(pending), 32'($countones(m_valid)));
        for (int n = 0; n < 8; n++) begin
            check($sformatf("out%0d", n), dut_out[n], m_data[n]);
        end
    endtask

    initial begin
        m_valid = '0;
        for (int n = 0; n < 8; n++) m_data[n] = '0;

        drive(1, 1, 2, 32'h1, 8'h00);
        drive(1, 1, 2, 32'h1, 8'h00);
        drive(0, 0, 0, 32'h0, 8'h00);
        check("t1_valid", 32'(out_valid), 32'h0);
        check("t1_pending", 32'(pending), 32'h0);

        drive(0, 1, 5, 32'hDEADBEEF, 8'h00);
        check("t2_out5", out5, 32'hDEADBEEF);
        check("t2_valid", 32'(out_valid), 32'h20);
        check("t2_pending", 32'(pending), 32'h1);
        drive(0, 1, 5, 32'h12345678, 8'h00);
        check("t2_hold", out5, 32'hDEADBEEF);
        drive(0, 0, 0, 32'h0, 8'hFF);

        for (int i = 0; i < 8; i++) drive(0, 1, i, 32'h10 + 32'(i), 8'h00);
        check("t3_pending", 32'(pending), 32'h8);
        check("t3_valid", 32'(out_valid), 32'hFF);
        for (int i = 0; i < 8; i++) drive(0, 1, i, 32'hBAD0, 8'h00);
        drive(0, 1, 0, 32'h99, 8'h01);
        check("t3_refill", out0, 32'h99);
        check("t3_pending8", 32'(pending), 32'h8);
        drive(0, 0, 0, 32'h0, 8'hFF);

        for (int k = 1; k <= 4; k++) begin
            drive(0, 1, 3, 32'(k), 8'h08);
            check("t4_out3", out3, 32'(k));
            check("t4_pending", 32'(pending), 32'h1);
        end
        drive(0, 0, 0, 32'h0, 8'hFF);

        drive(0, 1, 2, 32'h22, 8'h00);
        drive(0, 1, 6, 32'h66, 8'h00);
        drive(0, 1, 1, 32'hAA, 8'h44);
        check("t5_valid", 32'(out_valid), 32'h02);
        check("t5_pending", 32'(pending), 32'h1);
        check("t5_out1", out1, 32'hAA);
        drive(0, 0, 0, 32'h0, 8'hFF);

        for (int i = 0; i < 4; i++) drive(0, 1, i, 32'h40 + 32'(i), 8'h00);
        drive(1, 1, 4, 32'h55, 8'h00);
        check("t6_valid", 32'(out_valid), 32'h0);
        check("t6_pending", 32'(pending), 32'h0);
        check("t6_noacc", out4, 32'h0);
        drive(0, 1, 4, 32'h66, 8'h00);
        check("t6_resume", out4, 32'h66);
        check("t6_pending1", 32'(pending), 32'h1);

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 63) == 0), 1'($urandom), int'($urandom_range(0, 7)),
                  $urandom, 8'($urandom & $urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
